clk_step_ctrl: RTL
==================

CLK_STEP_CTRL -- requirements
Module: clk_step_ctrl

Interface
REQ-001 Parameter CNT_W, default 32: width of the executed-cycle counter.
REQ-002 Parameter LIM_W, default 16: width of the cycle-limit input.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 go  input  1  level; start or resume free-run execution.
REQ-006 step  input  1  level, sampled per cycle; request one single-step.
REQ-007 halt  input  1  level; stop execution.
REQ-008 clr  input  1  clear counter and return to IDLE.
REQ-009 cycle_limit  input  LIM_W  free-run cycle budget; 0 = unlimited.
REQ-010 cpu_en  output  1  clock enable to the datapath.
REQ-011 busy  output  1  high in RUN or STEP.
REQ-012 done  output  1  one-cycle pulse when cycle_limit is reached.
REQ-013 cycle_count  output  CNT_W  number of cycles with cpu_en high since the last clear.
REQ-014 state  output  2  current FSM state encoding.

Function
REQ-015 FSM states SHALL be IDLE=0, RUN=1, STEP=2, HALTED=3, held in a registered state.
REQ-016 cpu_en SHALL be combinational from state: 1 iff state is RUN or STEP; busy SHALL equal cpu_en.
REQ-017 Request priority SHALL be clr > halt > step > go, evaluated each rising edge.
REQ-018 clr SHALL, from any state, force state to IDLE and cycle_count to 0 at the next edge.
REQ-019 IDLE: go -> RUN; step -> STEP; halt alone -> HALTED.
REQ-020 RUN: halt -> HALTED; limit hit -> HALTED; otherwise remain in RUN.
REQ-021 STEP SHALL last exactly one cycle, then go to HALTED regardless of go; halt during STEP still takes it to HALTED.
REQ-022 HALTED: go -> RUN (cycle_count preserved); step -> STEP.
REQ-023 cycle_count SHALL increment by 1 on every edge where cpu_en=1 and clr=0, wrapping from 2^CNT_W-1 to 0.
REQ-024 A limit hit SHALL be defined as: state=RUN, cycle_limit!=0, and the run-local counter +1 == cycle_limit.
REQ-025 The run-local counter SHALL be zeroed on entry to RUN.
REQ-026 On a limit hit, done SHALL be 1 in the cycle of the HALTED transition and 0 otherwise; the cycle performing the hit still counts.
REQ-027 halt and a limit hit on the same edge SHALL give HALTED with done=1.
REQ-028 cycle_limit SHALL be sampled only on entry to RUN; changes during RUN SHALL be ignored.
REQ-029 Latency: go sampled at edge N SHALL give cpu_en=1 in the cycle following edge N.

Reset
REQ-030 While rst_n=0: state=IDLE, cpu_en=0, busy=0, done=0, cycle_count=0, run-local counter=0.
REQ-031 Reset asserted mid-RUN SHALL drop cpu_en asynchronously, without waiting for a clock edge.

Configuration
REQ-032 With macro CLK_STEP_BURST_EN defined:
- Add input step_len (8 bits).
- STEP SHALL last max(step_len,1) cycles, latched on STEP entry, then go to HALTED.
- halt or clr SHALL abort the burst.
REQ-033 Without CLK_STEP_BURST_EN: step_len is absent and STEP lasts exactly one cycle.

Structure
REQ-034 Package clk_ctrl_pkg SHALL hold the state encoding constants and the default CNT_W and LIM_W.
REQ-035 Sub-module clk_ctrl_counter SHALL implement the enable/clear/wrap counter, instantiated for both cycle_count and the run-local counter.

Verification
REQ-036 Reset check: rst_n=0 asserted mid-RUN -> cpu_en=0 immediately, cycle_count=0, state=0.
REQ-037 Limit run: cycle_limit=5, go pulse from IDLE -> exactly 5 cycles of cpu_en=1, done pulses on the fifth, state=3, cycle_count=5.
REQ-038 Single-step: step held 3 cycles from HALTED -> cpu_en=1 for 1 cycle, then HALTED (state=3), cycle_count +1; without CLK_STEP_BURST_EN, one step per step-entry.
REQ-039 Conflicting requests: halt=1 and go=1 in IDLE -> HALTED; clr=1 and halt=1 in RUN -> IDLE, cycle_count=0.
REQ-040 Wrap: CNT_W=4, cycle_limit=0, run 20 cycles -> cycle_count=4, done never asserted.
REQ-041 Burst (CLK_STEP_BURST_EN): step_len=3 -> cpu_en=1 for 3 cycles, then HALTED; step_len=0 -> 1 cycle.

Source files
------------

// File: rtl/clk_ctrl_pkg.sv
// Shared definitions for the clock-step controller: FSM state encoding and default widths.
package clk_ctrl_pkg;

  localparam int unsigned CntWDefault = 32;
  localparam int unsigned LimWDefault = 16;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StStep   = 2'd2,
    StHalted = 2'd3
  } state_e;

endpackage

// File: rtl/clk_ctrl_counter.sv
// Free-running counter with synchronous clear (dominant over enable) and natural wrap.
module clk_ctrl_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/clk_step_ctrl.sv
// Run/step/halt clock-enable controller with optional cycle budget.
// Define CLK_STEP_BURST_EN to add step_len_i and multi-cycle step bursts.
module clk_step_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault,
  parameter int unsigned LIM_W = LimWDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go_i,
  input  logic             step_i,
  input  logic             halt_i,
  input  logic             clr_i,
  input  logic [LIM_W-1:0] cycle_limit_i,
`ifdef CLK_STEP_BURST_EN
  input  logic [7:0]       step_len_i,
`endif
  output logic             cpu_en_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cycle_count_o,
  output logic [1:0]       state_o
);

  state_e           state_q, state_d;
  logic             step_q;
  logic             step_req;
  logic [LIM_W-1:0] limit_q, limit_d;
  logic [LIM_W-1:0] run_cnt;
  logic [LIM_W:0]   run_cnt_inc;
  logic             run_en, run_entry, run_cnt_clr;
  logic             limit_hit;
  logic             step_last;

  // A held step request yields one step per assertion.
  assign step_req    = step_i & ~step_q;
  assign cpu_en_o    = (state_q == StRun) || (state_q == StStep);
  assign busy_o      = cpu_en_o;
  assign state_o     = state_q;
  assign run_en      = (state_q == StRun);
  assign run_cnt_inc = {1'b0, run_cnt} + (LIM_W + 1)'(1);
  assign limit_hit   = run_en && (limit_q != '0) && (run_cnt_inc == {1'b0, limit_q});
  assign done_o      = limit_hit & ~clr_i;
  assign run_entry   = (state_d == StRun) && (state_q != StRun);
  assign run_cnt_clr = clr_i | run_entry;
  assign limit_d     = run_entry ? cycle_limit_i : limit_q;

`ifdef CLK_STEP_BURST_EN
  logic [7:0] burst_q, burst_d;

  always_comb begin
    burst_d = burst_q;
    if ((state_d == StStep) && (state_q != StStep)) begin
      burst_d = (step_len_i == 8'd0) ? 8'd1 : step_len_i;
    end else if (state_q == StStep) begin
      burst_d = burst_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_q <= 8'd0;
    end else begin
      burst_q <= burst_d;
    end
  end

  assign step_last = (burst_q == 8'd1);
`else
  assign step_last = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (halt_i)        state_d = StHalted;
          else if (step_req) state_d = StStep;
          else if (go_i)     state_d = StRun;
        end
        StRun: begin
          if (halt_i || limit_hit) state_d = StHalted;
        end
        StStep: begin
          if (halt_i || step_last) state_d = StHalted;
        end
        StHalted: begin
          if (halt_i)        state_d = StHalted;
          else if (step_req) state_d = StStep;
          else if (go_i)     state_d = StRun;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      step_q  <= 1'b0;
      limit_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_i;
      limit_q <= limit_d;
    end
  end

  clk_ctrl_counter #(
    .Width(CNT_W)
  ) u_cycle_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (cpu_en_o),
    .clr_i  (clr_i),
    .count_o(cycle_count_o)
  );

  // Run-local counter restarts on every entry to RUN.
  clk_ctrl_counter #(
    .Width(LIM_W)
  ) u_run_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (run_en),
    .clr_i  (run_cnt_clr),
    .count_o(run_cnt)
  );

endmodule
